// File: rtl/cabac_pair_serializer_pkg.sv
// Shared definitions for the CABAC pair serializer: pair type codes, pair width, group size.
// Shared by cabac_pair_serializer and cabac_pair_pri_enc.
package cabac_pair_serializer_pkg;

  localparam int PAIR_W   = 11;
  localparam int GROUP_N  = 8;
  localparam int GROUP_W  = PAIR_W * GROUP_N;
  localparam int IDX_W    = 3;
  localparam int BINCNT_W = 6;

  typedef enum logic [1:0] {
    PT_REGULAR = 2'b00,
    PT_EMPTY   = 2'b01,
    PT_BYPASS  = 2'b10,
    PT_RSVD    = 2'b11
  } pair_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef logic [PAIR_W-1:0] pair_t;

  // Empty and reserved pairs carry no bins and are never forwarded.
  function automatic logic pair_is_live(input pair_t p);
    return (pair_type_e'(p[10:9]) == PT_REGULAR) || (pair_type_e'(p[10:9]) == PT_BYPASS);
  endfunction

  function automatic logic [BINCNT_W-1:0] pair_bins(input pair_t p);
    if (pair_type_e'(p[10:9]) == PT_BYPASS) return BINCNT_W'(p[7:5]);
    return BINCNT_W'(1);
  endfunction

endpackage

// File: rtl/cabac_pair_serializer_pri_enc.sv
// Lowest-set-bit selector for the pending pair mask (module cabac_pair_pri_enc).
module cabac_pair_pri_enc
  import cabac_pair_serializer_pkg::*;
(
  input  logic [GROUP_N-1:0] mask,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    for (int i = GROUP_N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/cabac_pair_serializer.sv
// Serializes a group of 8 CABAC ctx pairs into a one-pair-per-cycle stream, dropping empty pairs.
// Optional bin counter port bin_cnt_o is built only with CABAC_PAIR_BINCNT_EN defined.
//
// state  | meaning
// S_IDLE | ready for a new group
// S_EMIT | presenting pending pairs in index order
// S_DONE | one-cycle completion pulse
module cabac_pair_serializer
  import cabac_pair_serializer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid_i,
  output logic               load_ready_o,
  input  logic [GROUP_W-1:0] pair_group_i,
  output logic               pair_valid_o,
  output logic [PAIR_W-1:0]  pair_o,
  input  logic               pair_ready_i,
  output logic               done_o
`ifdef CABAC_PAIR_BINCNT_EN
  ,
  output logic [BINCNT_W-1:0] bin_cnt_o
`endif
);

  state_e             state_q, state_d;
  pair_t              pairs_q [GROUP_N];
  logic [GROUP_N-1:0] mask_q, load_mask, mask_clr;
  logic [IDX_W-1:0]   sel_idx;
  logic               mask_any;
  pair_t              sel_pair;
  logic               accept, xfer;

  always_comb begin
    load_mask = '0;
    for (int k = 0; k < GROUP_N; k++) begin
      load_mask[k] = pair_is_live(pair_group_i[k*PAIR_W +: PAIR_W]);
    end
  end

  cabac_pair_pri_enc u_pri_enc (
    .mask (mask_q),
    .idx  (sel_idx),
    .any  (mask_any)
  );

  assign sel_pair = pairs_q[sel_idx];
  assign mask_clr = mask_q & ~(GROUP_N'(1) << sel_idx);

  always_comb begin
    state_d      = state_q;
    load_ready_o = 1'b0;
    pair_valid_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready_o = 1'b1;
        if (load_valid_i) state_d = (|load_mask) ? S_EMIT : S_DONE;
      end
      S_EMIT: begin
        pair_valid_o = mask_any;
        if (pair_ready_i && (mask_clr == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = load_ready_o & load_valid_i;
  assign xfer   = pair_valid_o & pair_ready_i;
  assign pair_o = pair_valid_o ? sel_pair : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      for (int k = 0; k < GROUP_N; k++) pairs_q[k] <= '0;
    end else if (accept) begin
      mask_q <= load_mask;
      for (int k = 0; k < GROUP_N; k++) pairs_q[k] <= pair_group_i[k*PAIR_W +: PAIR_W];
    end else if (xfer) begin
      mask_q <= mask_clr;
    end
  end

`ifdef CABAC_PAIR_BINCNT_EN
  // Holds the last group's total through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst)         bin_cnt_o <= '0;
    else if (accept) bin_cnt_o <= '0;
    else if (xfer)   bin_cnt_o <= bin_cnt_o + pair_bins(sel_pair);
  end
`endif

endmodule

// File: tb/tb_cabac_pair_serializer.sv
// Scoreboard bench for cabac_pair_serializer; bin count checks active with CABAC_PAIR_BINCNT_EN.
module tb_cabac_pair_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid_i = 1'b0;
  logic        pair_ready_i = 1'b0;
  logic [87:0] pair_group_i = '0;
  logic        load_ready_o, pair_valid_o, done_o;
  logic [10:0] pair_o;
`ifdef CABAC_PAIR_BINCNT_EN
  logic [5:0]  bin_cnt_o;
`endif

  int          checks = 0;
  int          fails  = 0;
  logic [10:0] exp_q[$];
  int          exp_bins = 0;
  int          rdy_mode = 0;

  localparam logic [10:0] E = 11'b01_0_000_00000;

  always #5 clk = ~clk;

  cabac_pair_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .pair_group_i (pair_group_i),
    .pair_valid_o (pair_valid_o),
    .pair_o       (pair_o),
    .pair_ready_i (pair_ready_i),
    .done_o       (done_o)
`ifdef CABAC_PAIR_BINCNT_EN
    ,
    .bin_cnt_o    (bin_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [87:0] grp(input logic [10:0] p0, p1, p2, p3, p4, p5, p6, p7);
    return {p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  function automatic logic [10:0] rnd_pair();
    logic [10:0] p;
    int t;
    t = $urandom_range(0, 3);
    p = 11'($urandom_range(0, 2047));
    p[10:9] = 2'(t);
    if (t == 2) p[7:5] = 3'($urandom_range(1, 5));
    return p;
  endfunction

  // Reference: pairs in index order, types 00/10 kept, bins = 1 or bypass count.
  task automatic model_push(input logic [87:0] g);
    logic [10:0] p;
    exp_bins = 0;
    for (int k = 0; k < 8; k++) begin
      p = g[k*11 +: 11];
      if (p[10:9] == 2'b00) begin
        exp_q.push_back(p);
        exp_bins += 1;
      end else if (p[10:9] == 2'b10) begin
        exp_q.push_back(p);
        exp_bins += int'(p[7:5]);
      end
    end
  endtask

  task automatic load(input logic [87:0] g);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!load_ready_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!load_ready_o) begin
      chk("load_ready_timeout", 32'(load_ready_o), 32'd1);
      return;
    end
    load_valid_i = 1'b1;
    pair_group_i = g;
    model_push(g);
    @(posedge clk); #1;
    load_valid_i = 1'b0;
    pair_group_i = 88'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !load_ready_o) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pair_ready_i = 1'b1;
        1:       pair_ready_i = 1'($urandom_range(0, 1));
        default: pair_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: samples at negedge, between driver updates and the next active edge.
  initial begin
    logic        done_arm, first_arm, held_v, post_rst, ready_arm;
    logic [10:0] held;
    done_arm = 0; first_arm = 0; held_v = 0; post_rst = 0; ready_arm = 0; held = '0;
    forever begin
      @(negedge clk);
      if (post_rst) begin
        chk("rst_pair_valid_o", 32'(pair_valid_o), 32'd0);
        chk("rst_pair_o", 32'(pair_o), 32'd0);
        chk("rst_load_ready_o", 32'(load_ready_o), 32'd1);
`ifdef CABAC_PAIR_BINCNT_EN
        chk("rst_bin_cnt_o", 32'(bin_cnt_o), 32'd0);
`endif
        post_rst = 0;
      end
      chk("done_o", 32'(done_o), 32'(done_arm));
      if (done_o) chk("done_pair_valid_o", 32'(pair_valid_o), 32'd0);
`ifdef CABAC_PAIR_BINCNT_EN
      if (done_o || ready_arm) chk("bin_cnt_o", 32'(bin_cnt_o), 32'(exp_bins));
`endif
      if (ready_arm) chk("load_ready_after_done", 32'(load_ready_o), 32'd1);
      if (first_arm) chk("first_pair_latency", 32'(pair_valid_o), 32'd1);
      if (held_v) begin
        chk("stall_pair_valid_o", 32'(pair_valid_o), 32'd1);
        chk("stall_pair_o", 32'(pair_o), 32'(held));
      end
      ready_arm = done_o && !rst;
      done_arm  = 0;
      first_arm = 0;
      held_v    = 0;
      if (rst) begin
        exp_q.delete();
        post_rst = 1;
      end else begin
        if (pair_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("pair_valid_o_unexpected", 32'(pair_valid_o), 32'd0);
          end else begin
            chk("pair_o", 32'(pair_o), 32'(exp_q[0]));
            if (pair_ready_i) begin
              void'(exp_q.pop_front());
              if (exp_q.size() == 0) done_arm = 1;
            end else begin
              held_v = 1;
              held   = pair_o;
            end
          end
        end
        if (load_valid_i && load_ready_o) begin
          if (exp_q.size() == 0) done_arm = 1;
          else                   first_arm = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [87:0] g;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // two regular pairs then six empties
    rdy_mode = 0;
    load(grp(11'b00_1_001_00011, 11'b00_1_001_00010, E, E, E, E, E, E));
    wait_idle();

    // all-empty group
    load(grp(E, E, E, E, E, E, E, E));
    wait_idle();

    // regular + bypass with a 3-cycle stall
    @(negedge clk); rdy_mode = 2;
    load(grp(11'b00_0_010_00101, E, E, E, E, E, 11'b10_0_101_11100, E));
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    wait_idle();

    // reserved type in slot 3 is skipped
    @(negedge clk); rdy_mode = 1;
    load(grp(11'b00_1_000_00001, 11'b00_0_111_11111, 11'b10_1_011_10100,
             11'b11_1_111_11111, 11'b00_1_100_01010, E, 11'b10_0_001_10000, 11'b00_0_000_00000));
    wait_idle();

    // reset mid-EMIT with two pairs pending
    @(negedge clk); rdy_mode = 2;
    load(grp(11'b00_1_010_00111, 11'b10_0_010_11000, E, E, E, E, E, E));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); rdy_mode = 0;
    load(grp(E, 11'b00_0_011_00110, E, 11'b10_1_100_11110, E, E, E, 11'b00_1_101_00001));
    wait_idle();

    // load_valid_i toggled with new data during EMIT is ignored
    @(negedge clk); rdy_mode = 1;
    for (int k = 0; k < 8; k++) g[k*11 +: 11] = {2'b00, 9'($urandom_range(0, 511))};
    load(g);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      load_valid_i = 1'($urandom_range(0, 1));
      pair_group_i = 88'({$urandom(), $urandom(), $urandom()});
    end
    load_valid_i = 1'b0;
    wait_idle();

    // randomized groups
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); rdy_mode = $urandom_range(0, 1);
      for (int k = 0; k < 8; k++) g[k*11 +: 11] = rnd_pair();
      load(g);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
